ring_decoder_monitor: RTL
=========================

// Module: ring_decoder_monitor
// PURPOSE
//   Receive-side companion to our one-hot ring counters. Samples a WIDTH-bit
//   one-hot ring code and decodes it to a binary index.
//   Checks both that the code is one-hot and that it follows the ring's rotate-left
//   sequence: bit index advances by +1 mod WIDTH (1000->0001->0010->0100->1000).
//   Reports lock status and error counts to the status/debug logic.
// PARAMETERS
//   WIDTH     4  ring length (bits in ring_in); >=2
//   LOCK_CNT  2  consecutive good transitions required to declare lock; >=1
//   ERR_CNT_W 8  width of saturating error counter
//   (derived localparam IDX_W = $clog2(WIDTH))
// PORTS
//   clk        in   1          rising-edge clock
//   reset_n    in   1          asynchronous, active-low reset
//   sample_en  in   1          ring_in is valid this cycle
//   ring_in    in   WIDTH      one-hot ring code under test
//   clr_err    in   1          synchronous clear of err_count
//   idx        out  IDX_W      decoded bit position of last good sample
//   idx_valid  out  1          1-cycle pulse: idx updated from a one-hot sample
//   onehot_err out  1          1-cycle pulse: sample had popcount != 1
//   seq_err    out  1          1-cycle pulse: in LOCKED, sample != expected next
//   locked     out  1          level: FSM is in LOCKED
//   err_count  out  ERR_CNT_W  saturating count of onehot_err + seq_err events
// BEHAVIOUR
//   - All outputs registered. Latency 1 clk from sample_en to outputs.
//   - Reset (async assert, any time incl. mid-sequence):
//     idx=0, idx_valid=0, onehot_err=0, seq_err=0, locked=0, err_count=0;
//     FSM=UNLOCKED, prev_idx=0, good_cnt=0.
//   - sample_en=0: pulse outputs go 0; idx, FSM, prev_idx, good_cnt, err_count hold.
//     Gaps of any length are legal and are not errors.
//   - expected = (prev_idx==WIDTH-1) ? 0 : prev_idx+1. The WIDTH-1 -> 0 wrap is legal.
//   - On sample_en with a non-one-hot sample (all-zero or >1 bit set):
//     onehot_err=1, idx_valid=0, idx holds, FSM->UNLOCKED, good_cnt=0,
//     err_count+1.
//   - On sample_en with a one-hot sample decoding to d:
//     idx=d, idx_valid=1, prev_idx<=d. FSM behaves as follows:
//     UNLOCKED: ->ACQUIRE, good_cnt=0. No sequence check.
//     ACQUIRE : d==expected -> good_cnt+1; if good_cnt+1==LOCK_CNT -> LOCKED.
//               d!=expected -> good_cnt=0, stay in ACQUIRE, no seq_err.
//     LOCKED  : d==expected -> stay in LOCKED.
//               d!=expected -> seq_err=1, err_count+1, ->ACQUIRE, good_cnt=0.
//   - locked = (FSM==LOCKED) and is registered alongside the FSM state.
//   - err_count saturates at all-ones and never wraps.
//   - clr_err: err_count<=0. Clear wins over a same-cycle increment.
//   - onehot_err and seq_err are never both 1 in the same cycle.
// STRUCTURE
//   - Package ring_pkg: typedef enum ring_mon_state_e {UNLOCKED, ACQUIRE, LOCKED}
//     and a shared DEFAULT_RING_WIDTH=4 constant.
//   - Sub-module onehot_to_bin (#(WIDTH)): combinational decoder.
//     In: vec. Out: bin (IDX_W), is_onehot. All-zero input gives is_onehot=0, bin=0.
//   - Top level contains the FSM, prev_idx/good_cnt registers, error counter
//     and output registers.
// TESTING
//   1) Reset, then samples 1000,0001,0010 on consecutive sample_en
//      -> idx 3,0,1; locked=1 one clk after the third sample.
//   2) In LOCKED, continue 0100,1000,0001 -> idx 2,3,0, no errors
//      (covers the 3->0 wrap).
//   3) In LOCKED at idx=0, send 0100 -> seq_err pulse, idx=2, locked=0,
//      err_count=1. Then 1000,0001 -> relock.
//   4) Send 0000, then 0110 -> onehot_err pulse each time, idx_valid=0,
//      idx unchanged, locked=0, err_count +2.
//   5) ERR_CNT_W=4: 20 bad samples -> err_count=15 (saturated).
//      clr_err in the same cycle as a bad sample -> err_count=0.
//   6) Locked; hold sample_en=0 for 7 clk, then send expected code -> no error,
//      locked stays 1. Drop reset_n mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and constants for the one-hot ring counter family.
package ring_pkg;

    localparam int DEFAULT_RING_WIDTH = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } ring_mon_state_e;

endpackage : ring_pkg

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary decoder with a one-hot validity flag.
// All-zero input gives is_onehot=0 and bin=0.
module onehot_to_bin
    import ring_pkg::*;
#(
    parameter int WIDTH = DEFAULT_RING_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] bin,
    output logic             is_onehot
);

    // OR together the indices of all set bits; only meaningful when one-hot.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                bin = bin | IDX_W'(i);
            end else begin
                bin = bin;
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    always_comb begin
        is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
    end

endmodule : onehot_to_bin

// File: rtl/ring_decoder_monitor.sv
// Receive-side monitor for one-hot ring counters: decodes the code, checks
// one-hot validity and rotate-left sequencing, and tracks lock and error count.
module ring_decoder_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_RING_WIDTH,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 clr_err,
    output logic [IDX_W-1:0]     idx,
    output logic                 idx_valid,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);

    ring_mon_state_e      state_q,      state_d;
    logic [GC_W-1:0]      good_cnt_q,   good_cnt_d;
    logic [IDX_W-1:0]     prev_idx_q,   prev_idx_d;
    logic [IDX_W-1:0]     idx_q,        idx_d;
    logic                 idx_valid_q,  idx_valid_d;
    logic                 onehot_err_q, onehot_err_d;
    logic                 seq_err_q,    seq_err_d;
    logic                 locked_q,     locked_d;
    logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;

    logic [IDX_W-1:0]     dec_idx_s;
    logic                 is_onehot_s;
    logic [IDX_W-1:0]     expected_s;
    logic                 match_s;
    logic [GC_W-1:0]      good_cnt_inc_s;

    onehot_to_bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .vec       (ring_in),
        .bin       (dec_idx_s),
        .is_onehot (is_onehot_s)
    );

    // Next ring position after prev_idx, wrapping WIDTH-1 back to 0.
    always_comb begin
        if (prev_idx_q == IDX_W'(WIDTH - 1)) begin
            expected_s = '0;
        end else begin
            expected_s = prev_idx_q + IDX_W'(1);
        end
        match_s        = (dec_idx_s == expected_s);
        good_cnt_inc_s = good_cnt_q + GC_W'(1);
    end

    // Lock FSM next state plus decoded index and error pulses.
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        prev_idx_d   = prev_idx_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        if (sample_en) begin
            if (!is_onehot_s) begin
                onehot_err_d = 1'b1;
                state_d      = UNLOCKED;
                good_cnt_d   = '0;
            end else begin
                idx_d       = dec_idx_s;
                idx_valid_d = 1'b1;
                prev_idx_d  = dec_idx_s;
                case (state_q)
                    UNLOCKED: begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                    end
                    ACQUIRE: begin
                        if (!match_s) begin
                            good_cnt_d = '0;
                        end else if (good_cnt_inc_s == GC_W'(LOCK_CNT)) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_inc_s;
                        end
                    end
                    LOCKED: begin
                        if (!match_s) begin
                            seq_err_d  = 1'b1;
                            state_d    = ACQUIRE;
                            good_cnt_d = '0;
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                    default: begin
                        state_d    = UNLOCKED;
                        good_cnt_d = '0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == LOCKED);
    end

    // Saturating error counter; a clear beats a same-cycle increment.
    always_comb begin
        err_count_d = err_count_q;
        if (clr_err) begin
            err_count_d = '0;
        end else if ((onehot_err_d || seq_err_d) && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= UNLOCKED;
            good_cnt_q   <= '0;
            prev_idx_q   <= '0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            prev_idx_q   <= prev_idx_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;
            locked_q     <= locked_d;
            err_count_q  <= err_count_d;
        end
    end

    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign onehot_err = onehot_err_q;
    assign seq_err    = seq_err_q;
    assign locked     = locked_q;
    assign err_count  = err_count_q;

endmodule : ring_decoder_monitor
